// File: rtl/seg7_scan_decoder_if.sv
// Display-bus bundle for the seven-segment readback decoder.
// The scanned anode/segment lines go in, and the reconstructed digits come out.
interface seg7_scan_decoder_if #(
    parameter int DIGITS = 4
);
    logic [DIGITS-1:0]   an;
    logic [6:0]          seg;
    logic [4*DIGITS-1:0] bcd;
    logic [DIGITS-1:0]   blank;
    logic                valid;
    logic                err;

    modport master (output an, seg, input bcd, blank, valid, err);
    modport slave  (input an, seg, output bcd, blank, valid, err);
endinterface

// File: rtl/seg7_scan_decoder.sv
// Watches a multiplexed active-low seven-segment bus and rebuilds the BCD digits.
// It publishes a frame only after MATCH identical complete scan frames.
//
// state     | meaning
// ST_IDLE   | no single active anode (gap)
// ST_SETTLE | anode active, counting consecutive identical cycles
// ST_SAMPLE | captured segments decoded into the frame slot
// ST_HOLD   | activation already sampled, waiting for anode change
module seg7_scan_decoder #(
    parameter int DIGITS = 4,
    parameter int SETTLE = 4,
    parameter int MATCH  = 2
) (
    input logic                clk,
    input logic                rst_n,
    seg7_scan_decoder_if.slave bus
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(SETTLE + 1);
    localparam int MW = $clog2(MATCH + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_HOLD} state_t;

    state_t              state_q, state_d;
    logic [DIGITS-1:0]   an_q, an_last_q;
    logic [6:0]          seg_q;
    logic [CW-1:0]       cnt_q, cnt_d, run_c;
    logic [6:0]          smp_seg_q, smp_seg_d;
    logic [IW-1:0]       smp_idx_q, smp_idx_d, idx_c;
    logic [3:0]          zeros_c;
    logic                active_c, same_c;

    logic [DIGITS-1:0]   filled_q, filled_d;
    logic [4*DIGITS-1:0] slot_bcd_q, slot_bcd_d;
    logic [DIGITS-1:0]   slot_blank_q, slot_blank_d;
    logic [4*DIGITS-1:0] prev_bcd_q, prev_bcd_d;
    logic [DIGITS-1:0]   prev_blank_q, prev_blank_d;
    logic [MW-1:0]       match_q, match_d;
    logic                pub_q, pub_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [DIGITS-1:0]   blank_q, blank_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;

    logic [5:0]          dec_c;
    logic [DIGITS-1:0]   fill_c;
    logic [4*DIGITS-1:0] frame_bcd_c;
    logic [DIGITS-1:0]   frame_blank_c;

    // Returns {legal, blank, nibble}; the pattern is written g..a.
    function automatic logic [5:0] seg_decode(input logic [6:0] s);
        case (s)
            7'h40:   seg_decode = {2'b10, 4'd0};
            7'h79:   seg_decode = {2'b10, 4'd1};
            7'h24:   seg_decode = {2'b10, 4'd2};
            7'h30:   seg_decode = {2'b10, 4'd3};
            7'h19:   seg_decode = {2'b10, 4'd4};
            7'h12:   seg_decode = {2'b10, 4'd5};
            7'h02:   seg_decode = {2'b10, 4'd6};
            7'h78:   seg_decode = {2'b10, 4'd7};
            7'h00:   seg_decode = {2'b10, 4'd8};
            7'h10:   seg_decode = {2'b10, 4'd9};
            7'h7F:   seg_decode = {2'b11, 4'hF};
            default: seg_decode = 6'b00_0000;
        endcase
    endfunction

    always_comb begin
        zeros_c = 4'd0;
        idx_c   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an_q[i]) begin
                zeros_c = zeros_c + 4'd1;
                idx_c   = IW'(i);
            end
        end
        active_c = (zeros_c == 4'd1);
        same_c   = (an_q == an_last_q);

        if (!same_c)
            run_c = CW'(1);
        else if (cnt_q == CW'(SETTLE))
            run_c = cnt_q;
        else
            run_c = cnt_q + CW'(1);
        cnt_d = active_c ? run_c : '0;

        state_d = state_q;
        if (!active_c)
            state_d = ST_IDLE;
        else if (same_c && (state_q == ST_SAMPLE || state_q == ST_HOLD))
            state_d = ST_HOLD;
        else if (run_c == CW'(SETTLE))
            state_d = ST_SAMPLE;
        else
            state_d = ST_SETTLE;

        smp_seg_d = smp_seg_q;
        smp_idx_d = smp_idx_q;
        if (state_d == ST_SAMPLE) begin
            smp_seg_d = seg_q;
            smp_idx_d = idx_c;
        end
    end

    always_comb begin
        filled_d      = filled_q;
        slot_bcd_d    = slot_bcd_q;
        slot_blank_d  = slot_blank_q;
        prev_bcd_d    = prev_bcd_q;
        prev_blank_d  = prev_blank_q;
        match_d       = match_q;
        pub_d         = pub_q;
        bcd_d         = bcd_q;
        blank_d       = blank_q;
        valid_d       = 1'b0;
        err_d         = 1'b0;
        dec_c         = seg_decode(smp_seg_q);
        fill_c        = filled_q;
        frame_bcd_c   = slot_bcd_q;
        frame_blank_c = slot_blank_q;

        if (state_q == ST_SAMPLE) begin
            if (!dec_c[5]) begin
                err_d    = 1'b1;
                filled_d = '0;
                match_d  = '0;
            end else begin
                // Revisiting a filled slot means the scan wrapped early: start over.
                if (filled_q[smp_idx_q])
                    fill_c = '0;
                fill_c[smp_idx_q]                   = 1'b1;
                frame_bcd_c[{smp_idx_q, 2'b00} +: 4] = dec_c[3:0];
                frame_blank_c[smp_idx_q]            = dec_c[4];

                if (&fill_c) begin
                    if (frame_bcd_c == prev_bcd_q && frame_blank_c == prev_blank_q)
                        match_d = (match_q == MW'(MATCH)) ? match_q : match_q + MW'(1);
                    else
                        match_d = MW'(1);
                    prev_bcd_d   = frame_bcd_c;
                    prev_blank_d = frame_blank_c;
                    filled_d     = '0;
                    if (match_d == MW'(MATCH) &&
                        (!pub_q || frame_bcd_c != bcd_q || frame_blank_c != blank_q)) begin
                        bcd_d   = frame_bcd_c;
                        blank_d = frame_blank_c;
                        valid_d = 1'b1;
                        pub_d   = 1'b1;
                    end
                end else begin
                    filled_d     = fill_c;
                    slot_bcd_d   = frame_bcd_c;
                    slot_blank_d = frame_blank_c;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            an_q         <= '1;
            an_last_q    <= '1;
            seg_q        <= 7'h7F;
            cnt_q        <= '0;
            smp_seg_q    <= 7'h7F;
            smp_idx_q    <= '0;
            filled_q     <= '0;
            slot_bcd_q   <= '0;
            slot_blank_q <= '0;
            prev_bcd_q   <= '0;
            prev_blank_q <= '0;
            match_q      <= '0;
            pub_q        <= 1'b0;
            bcd_q        <= '0;
            blank_q      <= '1;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            an_q         <= bus.an;
            an_last_q    <= an_q;
            seg_q        <= bus.seg;
            cnt_q        <= cnt_d;
            smp_seg_q    <= smp_seg_d;
            smp_idx_q    <= smp_idx_d;
            filled_q     <= filled_d;
            slot_bcd_q   <= slot_bcd_d;
            slot_blank_q <= slot_blank_d;
            prev_bcd_q   <= prev_bcd_d;
            prev_blank_q <= prev_blank_d;
            match_q      <= match_d;
            pub_q        <= pub_d;
            bcd_q        <= bcd_d;
            blank_q      <= blank_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
        end
    end

    assign bus.bcd   = bcd_q;
    assign bus.blank = blank_q;
    assign bus.valid = valid_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed scan sequences against a frame-level reference model.
// Predicted valid/err pulses are queued with their due cycle and matched as they appear.
module tb_seg7_scan_decoder;
    localparam int DIGITS = 4;
    localparam int SETTLE = 4;
    localparam int MATCH  = 2;

    localparam logic [6:0] P0  = 7'h40;
    localparam logic [6:0] P2  = 7'h24;
    localparam logic [6:0] P4  = 7'h19;
    localparam logic [6:0] P5  = 7'h12;
    localparam logic [6:0] BL  = 7'h7F;
    localparam logic [6:0] BAD = 7'h7E;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   vcount = 0;
    int   ecount = 0;

    typedef struct {
        int          at;
        logic [15:0] bcd;
        logic [3:0]  blank;
    } exp_t;

    exp_t vq[$];
    exp_t eq[$];
    exp_t mon_e;

    logic [6:0]  pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [3:0]  m_filled;
    logic [15:0] m_slot_bcd, m_prev_bcd, m_pub_bcd;
    logic [3:0]  m_slot_blank, m_prev_blank, m_pub_blank;
    int          m_match;
    bit          m_pub;

    seg7_scan_decoder_if #(.DIGITS(DIGITS)) bus ();

    seg7_scan_decoder #(.DIGITS(DIGITS), .SETTLE(SETTLE), .MATCH(MATCH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_filled     = '0;
        m_slot_bcd   = '0;
        m_slot_blank = '0;
        m_prev_bcd   = '0;
        m_prev_blank = '0;
        m_pub_bcd    = '0;
        m_pub_blank  = 4'hF;
        m_match      = 0;
        m_pub        = 1'b0;
    endtask

    task automatic model_sample(input int idx, input logic [6:0] s, input int at);
        int d;
        bit blk;
        d   = -1;
        blk = 1'b0;
        for (int v = 0; v < 10; v++)
            if (pat[v] == s) d = v;
        if (s == 7'h7F) begin
            d   = 15;
            blk = 1'b1;
        end
        if (d < 0) begin
            eq.push_back('{at, m_pub_bcd, m_pub_blank});
            m_filled = '0;
            m_match  = 0;
            return;
        end
        if (m_filled[idx]) m_filled = '0;
        m_filled[idx]           = 1'b1;
        m_slot_bcd[idx*4 +: 4]  = d[3:0];
        m_slot_blank[idx]       = blk;
        if (m_filled == 4'hF) begin
            if (m_slot_bcd == m_prev_bcd && m_slot_blank == m_prev_blank)
                m_match = (m_match < MATCH) ? m_match + 1 : MATCH;
            else
                m_match = 1;
            m_prev_bcd   = m_slot_bcd;
            m_prev_blank = m_slot_blank;
            m_filled     = '0;
            if (m_match == MATCH &&
                (!m_pub || m_slot_bcd != m_pub_bcd || m_slot_blank != m_pub_blank)) begin
                m_pub       = 1'b1;
                m_pub_bcd   = m_slot_bcd;
                m_pub_blank = m_slot_blank;
                vq.push_back('{at, m_slot_bcd, m_slot_blank});
            end
        end
    endtask

    // Hold one bus value for n cycles; rst_at>0 pulses reset on that cycle.
    task automatic drive(input logic [3:0] an_v, input logic [6:0] seg_v,
                         input int n, input int rst_at);
        int start;
        int zeros;
        int idx;
        zeros = 0;
        idx   = 0;
        for (int i = 0; i < DIGITS; i++)
            if (!an_v[i]) begin
                zeros++;
                idx = i;
            end
        bus.an  = an_v;
        bus.seg = seg_v;
        start   = cyc;
        for (int k = 1; k <= n; k++) begin
            if (k == rst_at) rst_n = 1'b0;
            @(posedge clk);
            #1;
            if (k == rst_at) begin
                rst_n = 1'b1;
                model_reset();
                start = cyc;
                check("rst_bcd",   bus.bcd,   16'h0000);
                check("rst_blank", bus.blank, 4'hF);
                check("rst_valid", bus.valid, 1'b0);
                check("rst_err",   bus.err,   1'b0);
            end
            if (zeros == 1 && cyc - start == SETTLE)
                model_sample(idx, seg_v, cyc + 2);
        end
    endtask

    task automatic scan_frame(input logic [6:0] s0, s1, s2, s3,
                              input int d2 = 8, input int rst2 = 0);
        drive(4'b1110, s0, 8, 0);
        drive(4'b1101, s1, 8, 0);
        drive(4'b1011, s2, d2, rst2);
        drive(4'b0111, s3, 8, 0);
    endtask

    always @(negedge clk) begin
        if (bus.valid === 1'b1) begin
            vcount++;
            check("valid_expected", vq.size() != 0, 1'b1);
            if (vq.size() != 0) begin
                mon_e = vq.pop_front();
                check("valid_cycle", cyc, mon_e.at);
                check("valid_bcd",   bus.bcd, mon_e.bcd);
                check("valid_blank", bus.blank, mon_e.blank);
            end
        end
        if (bus.err === 1'b1) begin
            ecount++;
            check("err_expected", eq.size() != 0, 1'b1);
            if (eq.size() != 0) begin
                mon_e = eq.pop_front();
                check("err_cycle", cyc, mon_e.at);
                check("err_bcd_kept", bus.bcd, mon_e.bcd);
            end
        end
    end

    initial begin
        bus.an  = 4'hF;
        bus.seg = 7'h7F;
        rst_n   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_bcd",   bus.bcd,   16'h0000);
        check("reset_blank", bus.blank, 4'hF);
        check("reset_valid", bus.valid, 1'b0);
        check("reset_err",   bus.err,   1'b0);
        rst_n = 1'b1;

        repeat (10) scan_frame(P4, P2, P0, P2);
        check("pulses_2024", vcount, 1);
        check("bcd_2024",    bus.bcd, 16'h2024);
        check("blank_2024",  bus.blank, 4'h0);

        scan_frame(P5, P2, P0, P2);
        repeat (2) scan_frame(P4, P2, P0, P2);
        check("pulses_single_2025", vcount, 1);
        repeat (2) scan_frame(P5, P2, P0, P2);
        check("pulses_2025", vcount, 2);
        check("bcd_2025",    bus.bcd, 16'h2025);

        scan_frame(P4, BAD, P0, P2);
        check("err_count_1", ecount, 1);
        check("bcd_after_err", bus.bcd, 16'h2025);
        repeat (3) scan_frame(P4, P2, P0, P2);
        check("bcd_back_2024", bus.bcd, 16'h2024);

        scan_frame(P4, P2, P0, BAD);
        repeat (2) scan_frame(P4, P2, P0, P2);
        check("err_count_2", ecount, 2);

        vcount = 0;
        repeat (3) scan_frame(P4, P2, P0, P2, 3);
        drive(4'b0011, P2, 8, 0);
        repeat (2) scan_frame(P5, P2, P0, P2, 3);
        check("short_no_valid", vcount, 0);
        check("short_no_err",   ecount, 2);

        repeat (3) scan_frame(P4, P2, P0, BL);
        check("bcd_blank3",   bus.bcd,   16'hF024);
        check("blank_blank3", bus.blank, 4'b1000);

        vcount = 0;
        scan_frame(P4, P2, P0, BL, 8, 3);
        repeat (3) scan_frame(P4, P2, P0, BL);
        check("valid_after_reset", vcount, 1);
        check("bcd_after_reset",   bus.bcd, 16'hF024);

        drive(4'hF, 7'h7F, 10, 0);
        check("valid_queue_drained", vq.size(), 0);
        check("err_queue_drained",   eq.size(), 0);
        check("final_bcd",   bus.bcd,   m_pub_bcd);
        check("final_blank", bus.blank, m_pub_blank);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
